register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined core.
//  Provides NUM_RD read ports and NUM_WR write ports, plus optional same-cycle write-to-read bypass.
//  Keeps a per-register busy scoreboard: set at issue, cleared at writeback. Decode uses it to detect RAW hazards.
//  Sits between decode (rsel/issue) and writeback (wen/wsel/wdat).
// PARAMETERS
//  DATA_W   32  register width in bits
//  NUM_REGS 32  register count, power of 2, >=2; AW = $clog2(NUM_REGS)
//  NUM_RD   2   read ports, 1..4
//  NUM_WR   1   write ports, 1..2
//  BYPASS   1   1: same-cycle writes are forwarded to reads; 0: reads return the pre-write value
// PORTS
//  CLK      in   1              rising-edge clock
//  RST      in   1              synchronous active-high reset
//  wen      in   NUM_WR         per-port write enable
//  wsel     in   NUM_WR*AW      per-port write register index
//  wdat     in   NUM_WR*DATA_W  per-port write data
//  rsel     in   NUM_RD*AW      per-port read register index
//  rdat     out  NUM_RD*DATA_W  per-port read data (combinational)
//  rrdy     out  NUM_RD         read-port operand valid: register not busy, or bypassed this cycle
//  iss_en   in   1              issue strobe: mark iss_sel busy
//  iss_sel  in   AW             destination register of the issuing instruction
//  busy     out  NUM_REGS       scoreboard vector, registered
// BEHAVIOUR
//  Reset
//   - RST high at a rising CLK edge: all registers <= 0, busy <= 0.
//   - Reset overrides any write or issue on the same edge.
//   - Outputs after reset: rdat = 0, rrdy = all 1, busy = 0.
//  Register 0
//   - Hardwired to 0: writes are ignored and reads always return 0.
//   - busy[0] is always 0 (issue to reg 0 is ignored), so rrdy is 1 for rsel = 0.
//  Writes
//   - Committed at the rising edge when wen[i]=1 and wsel[i]!=0; registered latency is 1 cycle.
//   - Two ports writing the same register in one cycle: the higher port index wins.
//  Reads
//   - Combinational, zero latency.
//   - BYPASS=1: if any wen[i] targets rsel[j] (nonzero), rdat[j] = wdat of the highest such i, else the stored value.
//   - BYPASS=0: rdat[j] = stored value only.
//  Scoreboard
//   - Issue: iss_en=1 and iss_sel!=0 sets busy[iss_sel] at the next edge.
//   - Writeback: wen[i]=1 to register r clears busy[r] at the next edge.
//   - Simultaneous issue and writeback to the same r: issue wins and busy stays 1 (a new producer owns r).
//   - Issue to an already-busy register keeps busy=1 (no count; in-order single producer).
//  rrdy
//   - rrdy[j] = ~busy[rsel[j]], or (BYPASS=1 and the write port hits rsel[j] this cycle).
//   - With BYPASS=0 and a same-cycle writeback: rrdy[j] = 0 this cycle, 1 the next.
//  Index width
//   - Indices are AW bits. No out-of-range index exists, because NUM_REGS is a power of 2.
// TESTING
//  1. Reset: assert RST with wen=1, wsel=5, wdat=0xAAAA_AAAA -> after the edge, reg5=0, busy=0, rrdy=all 1.
//  2. Reg 0: wen=1, wsel=0, wdat=0xDEADBEEF, then iss_sel=0 -> rdat(rsel=0)=0, busy[0]=0.
//  3. Bypass (BYPASS=1): wsel=7, wdat=0x1234, rsel0=7 in the same cycle -> rdat0=0x1234 and rrdy0=1 that cycle.
//     With BYPASS=0 -> old value and rrdy0=0 that cycle, then 0x1234 next cycle.
//  4. Dual-write conflict (NUM_WR=2): both ports write reg 9, port0=0x11, port1=0x22 -> reg9=0x22, and bypass returns 0x22.
//  5. Scoreboard: issue r3 -> busy[3]=1 next cycle, rrdy=0 on rsel=3.
//     Write r3 -> busy[3]=0 next cycle.
//     Issue r3 and write r3 in the same cycle -> busy[3] stays 1.
//  6. All read ports: NUM_RD=4 with rsel = 1,2,3,4 after writing 0x1..0x4 -> each rdat matches, independently.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file with optional same-cycle write-to-read bypass and a
// per-register busy scoreboard for RAW hazard detection in decode.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*AW-1:0]     wsel,
  input  logic [NUM_WR*DATA_W-1:0] wdat,
  input  logic [NUM_RD*AW-1:0]     rsel,
  output logic [NUM_RD*DATA_W-1:0] rdat,
  output logic [NUM_RD-1:0]        rrdy,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_sel,
  output logic [NUM_REGS-1:0]      busy
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic [AW-1:0]     wsel_a [NUM_WR];
  logic [DATA_W-1:0] wdat_a [NUM_WR];
  logic [AW-1:0]     rsel_a [NUM_RD];

  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wsel_a[i] = wsel[i*AW +: AW];
      wdat_a[i] = wdat[i*DATA_W +: DATA_W];
    end
    for (int j = 0; j < NUM_RD; j++) begin
      rsel_a[j] = rsel[j*AW +: AW];
    end
  end

  // Ports are scanned low to high so the highest-indexed writer to a register wins.
  // NOTE: every always_comb output starts from a full default so no path can infer a latch.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wen[i] && (wsel_a[i] != '0)) begin
        regs_d[wsel_a[i]] = wdat_a[i];
      end
    end
  end

  // Writeback clears first, issue then sets, so a new producer keeps ownership.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wen[i]) begin
        busy_d[wsel_a[i]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_sel] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: the storage array is reset here because the core relies on all
  // architectural registers reading 0 after reset; non-blocking assignments
  // keep every flop updating from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Register 0 is never written, so its storage stays at the reset value of 0.
  always_comb begin
    rdat = '0;
    rrdy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      logic              hit;
      logic [DATA_W-1:0] val;
      hit = 1'b0;
      val = regs_q[rsel_a[j]];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wen[i] && (wsel_a[i] == rsel_a[j]) && (rsel_a[j] != '0)) begin
            hit = 1'b1;
            val = wdat_a[i];
          end
        end
      end
      rdat[j*DATA_W +: DATA_W] = val;
      rrdy[j] = ~busy_q[rsel_a[j]] | hit;
    end
  end

  assign busy = busy_q;

endmodule
